// File: rtl/norm_check_vec_ctrl.sv
// Read controller for the norm-check datapath: walks every polynomial of a vector,
// one memory word per cycle, each polynomial starting at a random rotation offset.
//
// state | meaning
// IDLE  | waiting for norm_check_enable
// RD    | issuing one read per non-stalled cycle
// DRAIN | no issue; last in-flight word reaches the compare unit
// DONE  | one-cycle completion pulse
module norm_check_vec_ctrl #(
    parameter int MLDSA_N            = 256,
    parameter int COEFF_PER_ADDR     = 4,
    parameter int MAX_POLY           = 8,
    parameter int EARLY_EXIT         = 1,
    parameter int ABR_MEM_ADDR_WIDTH = 15,
    parameter int MODE_W             = 2,
    localparam int POLY_DEPTH        = MLDSA_N / COEFF_PER_ADDR,
    localparam int OFS_W             = $clog2(POLY_DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          zeroize,
    input  logic                          norm_check_enable,
    input  logic [MODE_W-1:0]             mode,
    input  logic [3:0]                    poly_cnt,
    input  logic [OFS_W-1:0]              randomness,
    input  logic [ABR_MEM_ADDR_WIDTH-1:0] mem_base_addr,
    input  logic                          stall,
    input  logic                          invalid_in,
    output logic [1:0]                    mem_rd_req_rd_wr_en,
    output logic [ABR_MEM_ADDR_WIDTH-1:0] mem_rd_req_addr,
    output logic [MODE_W-1:0]             mode_q,
    output logic                          check_enable,
    output logic                          poly_last,
    output logic                          invalid_sticky,
    output logic                          busy,
    output logic                          norm_check_done
);

    localparam int AW     = ABR_MEM_ADDR_WIDTH;
    localparam int PIDX_W = $clog2(MAX_POLY + 1);

    localparam logic [1:0] RW_IDLE = 2'b00;
    localparam logic [1:0] RW_READ = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RD    = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [OFS_W-1:0]    word_cnt_q, word_cnt_d;
    logic [PIDX_W-1:0]   poly_idx_q, poly_idx_d;
    logic [PIDX_W-1:0]   poly_num_q, poly_num_d;
    logic [OFS_W-1:0]    ofs_q, ofs_d;
    logic [AW-1:0]       base_q, base_d;
    logic [MODE_W-1:0]   mode_d;
    logic                check_enable_q, check_enable_d;
    logic                poly_last_q, poly_last_d;
    logic                invalid_sticky_q, invalid_sticky_d;

    logic                issue;
    logic                word_last;
    logic                poly_final;
    logic [OFS_W-1:0]    ofs_sum;
    logic [AW-1:0]       rd_addr;
    logic [PIDX_W-1:0]   poly_clamp;

    assign poly_clamp = (int'(poly_cnt) > MAX_POLY) ? PIDX_W'(MAX_POLY) : PIDX_W'(poly_cnt);
    assign word_last  = (word_cnt_q == OFS_W'(POLY_DEPTH - 1));
    assign poly_final = (poly_idx_q == (poly_num_q - PIDX_W'(1)));

    // Offset sum wraps naturally in OFS_W bits, keeping reads inside the polynomial.
    assign ofs_sum = ofs_q + word_cnt_q;
    assign rd_addr = base_q + AW'({poly_idx_q, ofs_sum});

    assign busy = (state_q != S_IDLE);

    always_comb begin
        state_d          = state_q;
        word_cnt_d       = word_cnt_q;
        poly_idx_d       = poly_idx_q;
        poly_num_d       = poly_num_q;
        ofs_d            = ofs_q;
        base_d           = base_q;
        mode_d           = mode_q;
        invalid_sticky_d = invalid_sticky_q | (busy & invalid_in);
        issue            = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (norm_check_enable) begin
                    mode_d           = mode;
                    base_d           = mem_base_addr;
                    poly_num_d       = poly_clamp;
                    word_cnt_d       = '0;
                    poly_idx_d       = '0;
                    ofs_d            = randomness;
                    invalid_sticky_d = 1'b0;
                    // An empty vector still passes through DRAIN so done lands on cycle 2.
                    state_d          = (poly_clamp == '0) ? S_DRAIN : S_RD;
                end
            end
            S_RD: begin
                issue = !stall;
                if (issue) begin
                    if (word_last) begin
                        word_cnt_d = '0;
                        poly_idx_d = poly_idx_q + PIDX_W'(1);
                        ofs_d      = randomness;
                        if (poly_final) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + OFS_W'(1);
                    end
                end
                if ((EARLY_EXIT != 0) && invalid_in) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (zeroize) begin
            state_d          = S_IDLE;
            word_cnt_d       = '0;
            poly_idx_d       = '0;
            poly_num_d       = '0;
            ofs_d            = '0;
            base_d           = '0;
            mode_d           = '0;
            invalid_sticky_d = 1'b0;
            issue            = 1'b0;
        end

        check_enable_d = issue;
        poly_last_d    = issue & word_last;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            word_cnt_q       <= '0;
            poly_idx_q       <= '0;
            poly_num_q       <= '0;
            ofs_q            <= '0;
            base_q           <= '0;
            mode_q           <= '0;
            check_enable_q   <= 1'b0;
            poly_last_q      <= 1'b0;
            invalid_sticky_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            word_cnt_q       <= word_cnt_d;
            poly_idx_q       <= poly_idx_d;
            poly_num_q       <= poly_num_d;
            ofs_q            <= ofs_d;
            base_q           <= base_d;
            mode_q           <= mode_d;
            check_enable_q   <= check_enable_d;
            poly_last_q      <= poly_last_d;
            invalid_sticky_q <= invalid_sticky_d;
        end
    end

    assign mem_rd_req_rd_wr_en = issue ? RW_READ : RW_IDLE;
    assign mem_rd_req_addr     = (state_q == S_RD) ? rd_addr : '0;
    assign check_enable        = check_enable_q;
    assign poly_last           = poly_last_q;
    assign invalid_sticky      = invalid_sticky_q;
    assign norm_check_done     = (state_q == S_DONE);

endmodule
